// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared sizing helpers for the streaming CNN datapath
package cnn_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return r;
  endfunction

  // Largest signed value representable in dw bits.
  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  // Smallest signed value representable in dw bits.
  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

  // Accumulator width that cannot overflow over cin full-width products plus bias.
  function automatic int acc_w(input int dw, input int cin);
    return 2 * dw + clog2(cin) + 1;
  endfunction

endpackage

// File: rtl/pointwise_conv_if.sv
// rtl/pointwise_conv_if.sv - pixel stream in / result stream out bundle
interface pointwise_conv_if #(
  parameter int DATA_W = 16
);
  logic                     pi_data_valid;
  logic signed [DATA_W-1:0] pi_data;
  logic                     po_data_valid;
  logic signed [DATA_W-1:0] po_data;
  logic                     frame_valid;

  modport master (
    output pi_data_valid, pi_data,
    input  po_data_valid, po_data, frame_valid
  );

  modport slave (
    input  pi_data_valid, pi_data,
    output po_data_valid, po_data, frame_valid
  );
endinterface

// File: rtl/pointwise_conv_sat_round_shift.sv
// rtl/pointwise_conv_sat_round_shift.sv - round half up, shift, optional ReLU, saturate
module sat_round_shift
  import cnn_pkg::*;
#(
  parameter int IN_W   = 35,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 0
) (
  input  logic signed [IN_W-1:0]   x_i,
  input  logic                     relu_en_i,
  output logic signed [DATA_W-1:0] y_o
);
  // One guard bit so adding the rounding half can never wrap.
  localparam int EW = IN_W + 1;
  localparam int HALF_SH = (FRAC_W > 0) ? FRAC_W - 1 : 0;
  localparam logic signed [EW-1:0] HALF = (FRAC_W > 0) ? (EW'(1) <<< HALF_SH) : '0;
  localparam logic signed [EW-1:0] MAXV = EW'(sat_max(DATA_W));
  localparam logic signed [EW-1:0] MINV = EW'(sat_min(DATA_W));

  logic signed [EW-1:0] ext_d;
  logic signed [EW-1:0] rnd_d;
  logic signed [EW-1:0] shf_d;

  // Rounding, scaling, ReLU and clamping to the output range.
  always_comb begin
    ext_d = EW'(x_i);
    rnd_d = ext_d + HALF;
    shf_d = rnd_d >>> FRAC_W;
    if (relu_en_i && shf_d[EW-1]) begin
      y_o = '0;
    end else if (shf_d > MAXV) begin
      y_o = MAXV[DATA_W-1:0];
    end else if (shf_d < MINV) begin
      y_o = MINV[DATA_W-1:0];
    end else begin
      y_o = shf_d[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/pointwise_conv.sv
// rtl/pointwise_conv.sv - channel-serial 1x1 convolution with frame tracking
module pointwise_conv
  import cnn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CIN    = 4,
  parameter int FRAC_W = 0,
  parameter int IMG_W  = 9
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         soft_clr,
  input  logic                         relu_en,
  input  logic [IMG_W-1:0]             image_size,
  input  logic                         cfg_wr_en,
  input  logic [clog2(CIN+1)-1:0]      cfg_wr_addr,
  input  logic signed [DATA_W-1:0]     cfg_wr_data,
  pointwise_conv_if.slave              px
);
  localparam int AW    = clog2(CIN + 1);
  localparam int CW    = (clog2(CIN) > 0) ? clog2(CIN) : 1;
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = acc_w(DATA_W, CIN);
  localparam int NW    = 2 * IMG_W;

  logic signed [DATA_W-1:0] weight_q [CIN];
  logic signed [DATA_W-1:0] bias_q;
  logic signed [DATA_W-1:0] w_sel_d;
  logic [CW-1:0]            ch_q;
  logic                     ch_last_d;
  logic                     beat_d;

  logic                     s1_valid_q, s1_first_q, s1_last_q;
  logic signed [PW-1:0]     s1_prod_q;
  logic                     acc_done_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     sum_valid_q;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [DATA_W-1:0] sat_d;

  logic                     po_valid_q, frame_q;
  logic signed [DATA_W-1:0] po_data_q;
  logic [NW-1:0]            pix_q, n_q, n_calc_d, n_eff_d;
  logic [IMG_W-1:0]         side_d;
  logic                     pix_last_d;

  // A beat in a soft_clr cycle is dropped.
  assign beat_d    = px.pi_data_valid && !soft_clr;
  assign ch_last_d = (ch_q == CW'(CIN - 1));

  // Coefficient file: writes land at the edge, so a same-cycle beat sees the old value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CIN; i++) weight_q[i] <= '0;
      bias_q <= '0;
    end else if (cfg_wr_en) begin
      for (int i = 0; i < CIN; i++) begin
        if (cfg_wr_addr == AW'(i)) weight_q[i] <= cfg_wr_data;
      end
      if (cfg_wr_addr == AW'(CIN)) bias_q <= cfg_wr_data;
    end
  end

  // Weight lookup for the current channel.
  always_comb begin
    w_sel_d = '0;
    for (int i = 0; i < CIN; i++) begin
      if (ch_q == CW'(i)) w_sel_d = weight_q[i];
    end
  end

  // Channel counter, holds through gaps.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     ch_q <= '0;
    else if (soft_clr)  ch_q <= '0;
    else if (beat_d)    ch_q <= ch_last_d ? '0 : ch_q + CW'(1);
  end

  // Stage 1: full-width product plus channel position tags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
    end else begin
      s1_valid_q <= beat_d;
      if (beat_d) begin
        s1_prod_q  <= PW'(px.pi_data) * PW'(w_sel_d);
        s1_first_q <= (ch_q == '0);
        s1_last_q  <= ch_last_d;
      end
    end
  end

  // Stage 2: accumulate across channels; restart on channel 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q      <= '0;
      acc_done_q <= 1'b0;
    end else if (soft_clr) begin
      acc_q      <= '0;
      acc_done_q <= 1'b0;
    end else begin
      acc_done_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) acc_q <= s1_first_q ? ACC_W'(s1_prod_q) : acc_q + ACC_W'(s1_prod_q);
    end
  end

  // Stage 2 tail: add the bias aligned to the weight fraction.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= acc_done_q && !soft_clr;
      if (acc_done_q) sum_q <= acc_q + (ACC_W'(bias_q) <<< FRAC_W);
    end
  end

  sat_round_shift #(
    .IN_W   (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_srs (
    .x_i       (sum_q),
    .relu_en_i (relu_en),
    .y_o       (sat_d)
  );

  // Frame size is latched at the first output of a frame; size 0 behaves as 1.
  always_comb begin
    side_d     = (image_size == '0) ? IMG_W'(1) : image_size;
    n_calc_d   = NW'(side_d) * NW'(side_d);
    n_eff_d    = (pix_q == '0) ? n_calc_d : n_q;
    pix_last_d = (pix_q == n_eff_d - NW'(1));
  end

  // Stage 3 output register and pixel counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_valid_q <= 1'b0;
      frame_q    <= 1'b0;
      po_data_q  <= '0;
      pix_q      <= '0;
      n_q        <= '0;
    end else if (soft_clr) begin
      po_valid_q <= 1'b0;
      frame_q    <= 1'b0;
      pix_q      <= '0;
      n_q        <= '0;
    end else begin
      po_valid_q <= sum_valid_q;
      frame_q    <= sum_valid_q && pix_last_d;
      if (sum_valid_q) begin
        po_data_q <= sat_d;
        n_q       <= n_eff_d;
        pix_q     <= pix_last_d ? '0 : pix_q + NW'(1);
      end
    end
  end

  assign px.po_data_valid = po_valid_q;
  assign px.po_data       = po_data_q;
  assign px.frame_valid   = frame_q;
endmodule
